// File: rtl/interrupt_control_logic.sv
// 8259A-style interrupt sequencer: IRR/ISR/IMR bookkeeping, fixed/rotating priority,
// two-pulse INTA vector delivery, OCW2 EOI/rotate commands and status readback.
module interrupt_control_logic #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] IR,
   input  logic       INTA_n,
   input  logic [7:0] ICW1,
   input  logic [7:0] ICW2,
   input  logic [7:0] ICW4,
   input  logic [7:0] OCW1,
   input  logic [7:0] OCW2,
   input  logic [7:0] OCW3,
   input  logic       write_flag,
   input  logic       cmd_is_ocw2,
   input  logic       read_cmd_to_ctrl_logic,
   output logic       write_flag_ACK,
   output logic       INT,
   output logic [7:0] data_out,
   output logic       data_out_en,
   output logic [7:0] IRR,
   output logic [7:0] ISR,
   output logic [7:0] IMR
);

   typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

   // Bundle layout: {read, write_flag, INTA_n, IR[7:0]}; INTA_n idles high so its flops reset to 1.
   localparam logic [10:0] SYNC_INIT = 11'h100;

   logic [10:0] async_in;
   logic [10:0] sync_reg [SYNC_STAGES];
   logic [10:0] prev_reg;
   logic [10:0] synced;

   state_t     state_reg;
   logic [2:0] lvl_reg;
   logic [7:0] data_out_reg;
   logic       den_reg;
   logic       int_reg;
   logic       ack_reg;
   logic [7:0] irr_reg, isr_reg, imr_reg;
   logic [2:0] lp_reg;
   logic       rot_aeoi_reg;

   logic [7:0] irr_next, isr_next, isr_set, isr_clr, irr_clr;
   logic [2:0] lp_next;
   logic       rot_aeoi_next;
   logic [7:0] ir_rise;
   logic       inta_fall, inta_rise, wf_rise, rd_sync;
   logic       ack1_entry, int_cause;
   logic [3:0] win, isr_hi;
   logic [2:0] win_rank, isr_rank, ocw2_l;
   logic [7:0] status_sel;
   logic       level_mode, aeoi;
   logic       unused_bits;

   assign async_in = {read_cmd_to_ctrl_logic, write_flag, INTA_n, IR};

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge reset) begin
               if (reset) sync_reg[gi] <= SYNC_INIT;
               else       sync_reg[gi] <= async_in;
            end
         end else begin : g_next
            always_ff @(posedge clk or posedge reset) begin
               if (reset) sync_reg[gi] <= SYNC_INIT;
               else       sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_reg <= SYNC_INIT;
      else       prev_reg <= synced;
   end

   assign synced    = sync_reg[SYNC_STAGES-1];
   assign ir_rise   = synced[7:0] & ~prev_reg[7:0];
   assign inta_fall = ~synced[8] & prev_reg[8];
   assign inta_rise = synced[8] & ~prev_reg[8];
   assign wf_rise   = synced[9] & ~prev_reg[9];
   assign rd_sync   = synced[10];

   assign level_mode  = ICW1[3];
   assign aeoi        = ICW4[1];
   assign ocw2_l      = OCW2[2:0];
   assign unused_bits = ^{ICW1[7:4], ICW1[2:0], ICW2[2:0], ICW4[7:2], ICW4[0], OCW2[4:3], OCW3[7:2]};

   // Returns {found, index} of the highest-priority set bit; rank 0 is lp+1.
   function automatic logic [3:0] pick(input logic [7:0] vec, input logic [2:0] lp);
      logic [3:0] r;
      logic [2:0] idx;
      r = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         idx = lp + 3'd1 + 3'(i);
         if (vec[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   assign win        = pick(irr_reg & ~imr_reg, lp_reg);
   assign isr_hi     = pick(isr_reg, lp_reg);
   assign win_rank   = win[2:0] - lp_reg - 3'd1;
   assign isr_rank   = isr_hi[2:0] - lp_reg - 3'd1;
   assign int_cause  = win[3] && (!isr_hi[3] || (win_rank < isr_rank));
   assign ack1_entry = (state_reg == IDLE) && inta_fall;

   always_comb begin
      isr_set       = 8'd0;
      isr_clr       = 8'd0;
      irr_clr       = 8'd0;
      lp_next       = lp_reg;
      rot_aeoi_next = rot_aeoi_reg;
      if (ack1_entry && win[3]) begin
         isr_set[win[2:0]] = 1'b1;
         irr_clr[win[2:0]] = 1'b1;
      end
      if ((state_reg == ACK2) && inta_rise && aeoi) begin
         isr_clr[lvl_reg] = 1'b1;
         if (rot_aeoi_reg) lp_next = lvl_reg;
      end
      if (wf_rise && cmd_is_ocw2) begin
         case (OCW2[7:5])
            3'b001: if (isr_hi[3]) isr_clr[isr_hi[2:0]] = 1'b1;
            3'b011: isr_clr[ocw2_l] = 1'b1;
            3'b101: if (isr_hi[3]) begin
               isr_clr[isr_hi[2:0]] = 1'b1;
               lp_next = isr_hi[2:0];
            end
            3'b111: begin
               isr_clr[ocw2_l] = 1'b1;
               lp_next = ocw2_l;
            end
            3'b110: lp_next = ocw2_l;
            3'b100: rot_aeoi_next = 1'b1;
            3'b000: rot_aeoi_next = 1'b0;
            default: ;
         endcase
      end
      isr_next = (isr_reg | isr_set) & ~isr_clr;
      // A fresh edge on a bit being acknowledged survives as a new request.
      if (level_mode) irr_next = synced[7:0] & ~irr_clr;
      else            irr_next = (irr_reg & ~irr_clr) | ir_rise;
   end

   always_comb begin
      case (OCW3[1:0])
         2'b10:   status_sel = irr_reg;
         2'b11:   status_sel = isr_reg;
         default: status_sel = imr_reg;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         lvl_reg      <= 3'd0;
         data_out_reg <= 8'd0;
         den_reg      <= 1'b0;
         int_reg      <= 1'b0;
         ack_reg      <= 1'b0;
         irr_reg      <= 8'd0;
         isr_reg      <= 8'd0;
         imr_reg      <= 8'd0;
         lp_reg       <= 3'd7;
         rot_aeoi_reg <= 1'b0;
      end else begin
         imr_reg      <= OCW1;
         irr_reg      <= irr_next;
         isr_reg      <= isr_next;
         lp_reg       <= lp_next;
         rot_aeoi_reg <= rot_aeoi_next;
         ack_reg      <= wf_rise;
         int_reg      <= ack1_entry ? 1'b0 : int_cause;
         case (state_reg)
            IDLE: begin
               if (inta_fall) begin
                  state_reg <= ACK1;
                  lvl_reg   <= win[3] ? win[2:0] : 3'd7;
                  den_reg   <= 1'b0;
               end else if (rd_sync) begin
                  den_reg      <= 1'b1;
                  data_out_reg <= status_sel;
               end else begin
                  den_reg <= 1'b0;
               end
            end
            ACK1: begin
               if (inta_fall) begin
                  state_reg    <= ACK2;
                  data_out_reg <= {ICW2[7:3], lvl_reg};
                  den_reg      <= 1'b1;
               end
            end
            ACK2: begin
               if (inta_rise) begin
                  state_reg <= IDLE;
                  den_reg   <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign write_flag_ACK = ack_reg;
   assign INT            = int_reg;
   assign data_out       = data_out_reg;
   assign data_out_en    = den_reg;
   assign IRR            = irr_reg;
   assign ISR            = isr_reg;
   assign IMR            = imr_reg;

endmodule

// File: tb/tb_interrupt_control_logic.sv
// Randomized scoreboard bench: a transaction-level model predicts every vector/status byte
// and the IRR/ISR/INT state after each operation.
module tb_interrupt_control_logic;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] IR = 8'd0;
   logic       INTA_n = 1'b1;
   logic [7:0] ICW1 = 8'd0, ICW2 = 8'h40, ICW4 = 8'd0;
   logic [7:0] OCW1 = 8'd0, OCW2 = 8'd0, OCW3 = 8'd0;
   logic       write_flag = 1'b0, cmd_is_ocw2 = 1'b0, read_cmd_to_ctrl_logic = 1'b0;
   logic       write_flag_ACK, INT, data_out_en;
   logic [7:0] data_out, IRR, ISR, IMR;

   interrupt_control_logic dut (
      .clk(clk), .reset(reset), .IR(IR), .INTA_n(INTA_n),
      .ICW1(ICW1), .ICW2(ICW2), .ICW4(ICW4), .OCW1(OCW1), .OCW2(OCW2), .OCW3(OCW3),
      .write_flag(write_flag), .cmd_is_ocw2(cmd_is_ocw2),
      .read_cmd_to_ctrl_logic(read_cmd_to_ctrl_logic),
      .write_flag_ACK(write_flag_ACK), .INT(INT), .data_out(data_out), .data_out_en(data_out_en),
      .IRR(IRR), .ISR(ISR), .IMR(IMR)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ops = 0;
   logic [7:0] exp_q[$];

   // Reference state: pending requests, in-service set, mask, lowest-priority level.
   logic [7:0] m_irr = 8'd0, m_isr = 8'd0, m_imr = 8'd0;
   int         m_lp = 7;
   bit         m_rot = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %02h, required %02h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int pick(input logic [7:0] v);
      for (int r = 0; r < 8; r++) begin
         int n = (m_lp + 1 + r) % 8;
         if (v[n]) return n;
      end
      return -1;
   endfunction

   function automatic int rank_of(input int n);
      return (n - m_lp - 1 + 16) % 8;
   endfunction

   function automatic logic model_int();
      int w = pick(m_irr & ~m_imr);
      int h = pick(m_isr);
      if (w < 0) return 1'b0;
      if (h < 0) return 1'b1;
      return rank_of(w) < rank_of(h);
   endfunction

   task automatic state_chk(input string tag);
      chk({tag, " IRR"}, IRR, m_irr);
      chk({tag, " ISR"}, ISR, m_isr);
      chk({tag, " INT"}, {7'd0, INT}, {7'd0, model_int()});
   endtask

   task automatic raise_ir(input logic [7:0] bits);
      IR = bits;
      cyc(6);
      IR = 8'd0;
      cyc(4);
      m_irr = m_irr | bits;
      $display("op %0d: raise IR %02h", ops, bits);
      state_chk("raise");
   endtask

   task automatic set_mask(input logic [7:0] v);
      OCW1 = v;
      m_imr = v;
      cyc(4);
      $display("op %0d: mask %02h", ops, v);
      chk("mask IMR", IMR, v);
      state_chk("mask");
   endtask

   task automatic inta();
      int w = pick(m_irr & ~m_imr);
      int lvl = (w < 0) ? 7 : w;
      logic [7:0] vec;
      if (w >= 0) begin
         m_isr[w] = 1'b1;
         m_irr[w] = 1'b0;
      end
      vec = {ICW2[7:3], 3'(lvl)};
      exp_q.push_back(vec);
      if (ICW4[1]) begin
         m_isr[lvl] = 1'b0;
         if (m_rot) m_lp = lvl;
      end
      INTA_n = 1'b0; cyc(3);
      INTA_n = 1'b1; cyc(3);
      INTA_n = 1'b0; cyc(4);
      INTA_n = 1'b1; cyc(6);
      $display("op %0d: inta expect vector %02h", ops, vec);
      state_chk("inta");
   endtask

   task automatic write_cmd(input logic [7:0] v, input logic is_ocw2);
      int acks = 0;
      int l = v[2:0];
      OCW2 = v;
      cmd_is_ocw2 = is_ocw2;
      write_flag = 1'b1;
      // write_flag is held well past the ACK; only one pulse is allowed.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (write_flag_ACK) acks++;
      end
      write_flag = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (write_flag_ACK) acks++;
      end
      cmd_is_ocw2 = 1'b0;
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL write ACK pulses: got %0d, required 1", acks);
      end
      if (is_ocw2) begin
         int h = pick(m_isr);
         case (v[7:5])
            3'b001: if (h >= 0) m_isr[h] = 1'b0;
            3'b011: m_isr[l] = 1'b0;
            3'b101: if (h >= 0) begin m_isr[h] = 1'b0; m_lp = h; end
            3'b111: begin m_isr[l] = 1'b0; m_lp = l; end
            3'b110: m_lp = l;
            3'b100: m_rot = 1'b1;
            3'b000: m_rot = 1'b0;
            default: ;
         endcase
      end
      $display("op %0d: write %02h ocw2=%0d", ops, v, is_ocw2);
      state_chk("write");
   endtask

   task automatic status_read(input logic [1:0] sel);
      logic [7:0] e;
      OCW3 = {6'd0, sel};
      e = (sel == 2'b10) ? m_irr : (sel == 2'b11) ? m_isr : m_imr;
      exp_q.push_back(e);
      read_cmd_to_ctrl_logic = 1'b1; cyc(4);
      read_cmd_to_ctrl_logic = 1'b0; cyc(4);
      $display("op %0d: read sel %0d expect %02h", ops, sel, e);
   endtask

   // Monitor: every new data_out_en assertion is one delivered byte.
   initial begin
      logic den_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (data_out_en && !den_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected output: got %02h, required none", data_out);
            end else begin
               chk("data_out", data_out, exp_q.pop_front());
            end
         end
         den_prev = data_out_en;
      end
   end

   initial begin
      cyc(3);
      chk("reset IRR", IRR, 8'd0);
      chk("reset ISR", ISR, 8'd0);
      chk("reset INT/en/ack", {5'd0, INT, data_out_en, write_flag_ACK}, 8'd0);
      chk("reset data_out", data_out, 8'd0);
      reset = 1'b0;
      cyc(2);

      // Level-triggered mode follows the synced line directly.
      ICW1 = 8'h08; IR = 8'h04; cyc(5);
      chk("level IRR high", IRR, 8'h04);
      IR = 8'h00; cyc(5);
      chk("level IRR low", IRR, 8'h00);
      ICW1 = 8'h00; cyc(2);

      raise_ir(8'h08); inta(); write_cmd(8'h20, 1'b1);
      raise_ir(8'h22); inta(); write_cmd(8'h20, 1'b1); inta(); write_cmd(8'h20, 1'b1);
      OCW1 = 8'h04; m_imr = 8'h04; cyc(2);
      raise_ir(8'h04);
      set_mask(8'h00); inta(); write_cmd(8'h20, 1'b1);
      write_cmd(8'hC4, 1'b1); raise_ir(8'h21); inta(); write_cmd(8'h65, 1'b1);
      inta(); write_cmd(8'h20, 1'b1); write_cmd(8'hC7, 1'b1);
      ICW4 = 8'h02; write_cmd(8'h80, 1'b1);
      raise_ir(8'h40); inta(); raise_ir(8'h81); inta(); inta();
      write_cmd(8'h00, 1'b1); ICW4 = 8'h00; write_cmd(8'h5A, 1'b0);
      raise_ir(8'h10); inta(); status_read(2'b11); status_read(2'b10); status_read(2'b01);
      write_cmd(8'h20, 1'b1);

      for (int k = 0; k < 150; k++) begin
         ops++;
         case ($urandom_range(0, 6))
            0, 1: raise_ir(8'($urandom) & 8'($urandom));
            2: set_mask(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0);
            3: begin
               ICW2 = 8'($urandom);
               ICW4 = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'h00;
               inta();
            end
            4: write_cmd({3'($urandom), 5'($urandom)}, 1'b1);
            5: write_cmd(8'h20, 1'b1);
            default: status_read(2'($urandom));
         endcase
      end

      // Reset inside the acknowledge sequence abandons it completely.
      ICW4 = 8'h00;
      raise_ir(8'h04);
      INTA_n = 1'b0; cyc(4);
      reset = 1'b1; cyc(1);
      chk("midreset IRR", IRR, 8'd0);
      chk("midreset ISR", ISR, 8'd0);
      chk("midreset flags", {5'd0, INT, data_out_en, write_flag_ACK}, 8'd0);
      chk("midreset data_out", data_out, 8'd0);
      INTA_n = 1'b1; cyc(2);
      reset = 1'b0; cyc(6);
      chk("midreset no output", {7'd0, data_out_en}, 8'd0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
